// File: rtl/mult_booth.sv
// mult_booth: sequential radix-2 Booth multiplier, one product bit-pair per clock.
//
// A start in IDLE latches the multiplicand and loads the multiplier into the
// product register. WIDTH iterations follow, and the result registers are
// written on the edge that enters DONE.
//
// Ports:
//   clock           sole clock, rising edge
//   reset           asynchronous, active-low
//   data_operandA   signed multiplicand, sampled at start
//   data_operandB   signed multiplier, sampled at start
//   ctrl_MULT       start request, honoured only in IDLE
//   data_result     low WIDTH bits of the signed product
//   data_exception  product does not fit in WIDTH signed bits
//   data_resultRDY  one-cycle completion strobe (the DONE cycle)
//   busy            operation in progress (RUN or DONE)
//   data_result_hi  high WIDTH bits of the product (only with MULT_BOOTH_HI_EN)
//
// Optional feature macro: MULT_BOOTH_HI_EN adds the data_result_hi output.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT
// RUN   | Booth iterations, one per clock, WIDTH in total
// DONE  | results registered, data_resultRDY high for this cycle

module mult_booth #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef MULT_BOOTH_HI_EN
    ,
    output logic [WIDTH-1:0] data_result_hi
`endif
);

    localparam int PW = 2*WIDTH + 2;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    p;
    logic [WIDTH-1:0] m;

    logic             last;
    logic [WIDTH:0]   acc, acc_next, m_ext;
    logic [PW-1:0]    p_next;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]   sign_span;

    assign last = (cnt == CW'(WIDTH-1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ctrl_MULT) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy           = (state != IDLE);
    assign data_resultRDY = (state == DONE);

    // Accumulator is WIDTH+1 bits with M sign-extended, so adding or
    // subtracting the most-negative multiplicand cannot overflow it.
    assign acc   = p[PW-1:WIDTH+1];
    assign m_ext = {m[WIDTH-1], m};

    always_comb begin
        acc_next = acc;
        case (p[1:0])
            2'b01:   acc_next = acc + m_ext;
            2'b10:   acc_next = acc - m_ext;
            default: acc_next = acc;
        endcase
    end

    // Add/subtract and arithmetic shift folded into one step; the old Booth
    // bit p[0] falls off the bottom.
    assign p_next  = {acc_next[WIDTH], acc_next, p[WIDTH:1]};
    assign product = p_next[2*WIDTH:1];

    // Fits in WIDTH signed bits only if the top WIDTH+1 bits are all copies
    // of the sign.
    assign sign_span = product[2*WIDTH-1:WIDTH-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt            <= '0;
            p              <= '0;
            m              <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef MULT_BOOTH_HI_EN
            data_result_hi <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_MULT) begin
                        m   <= data_operandA;
                        p   <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
                        cnt <= '0;
                    end
                end
                RUN: begin
                    p   <= p_next;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        data_result    <= product[WIDTH-1:0];
                        data_exception <= !((&sign_span) || !(|sign_span));
`ifdef MULT_BOOTH_HI_EN
                        data_result_hi <= product[2*WIDTH-1:WIDTH];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
